// File: rtl/dec_pkg.sv
// Shared definitions for the registered 3-to-8 decoder.
//   state_e    : FSM state encoding (IDLE, HOLD, GAP)
//   CNT_W      : width of the hold/gap interval counter
//   ACC_W      : width of the accepted-code counter
//   dec_onehot : 3-bit code to one-hot byte; shared with loopback benches
package dec_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    // code[2] is A (MSB); result has exactly bit 'code' set.
    function automatic logic [7:0] dec_onehot(input logic [2:0] code);
        logic [7:0] one;
        one = 8'd1;
        return one << code;
    endfunction

endpackage

// File: rtl/dec_cycle_counter.sv
// Loadable down-counter that times both the HOLD and the GAP interval.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   clr      : synchronous clear (highest priority)
//   load     : load load_val on the next edge
//   load_val : value to load
//   dec      : decrement on the next edge; stops at zero
//   zero     : count is zero
module dec_cycle_counter
    import dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/decoder_3x8_hold.sv
// Registered 3-to-8 decoder with a valid/ready input handshake. Each accepted
// code is driven one-hot on y for HOLD_CYCLES cycles, followed by GAP_CYCLES
// forced idle cycles before the next code can be taken.
// Optional feature macro: DEC_ACCEPT_COUNT_EN builds a saturating accepted-code
// counter on accept_cnt; without it accept_cnt is tied to zero.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   en         : block enable; low aborts a window in progress
//   in_valid   : code present
//   in_ready   : block can accept a code (IDLE and en)
//   code       : {A,B,C}, A is the MSB
//   y          : one-hot decoded output, zero outside HOLD
//   y_valid    : y carries a decoded code
//   busy       : FSM is not in IDLE
//   accept_cnt : number of accepted codes
module decoder_3x8_hold
    import dec_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  code,
    output logic [7:0]  y,
    output logic        y_valid,
    output logic        busy,
    output logic [15:0] accept_cnt
);

    // Counters are loaded with N-1 so that the interval spans exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [7:0]       y_q;
    logic [7:0]       y_d;

    logic             cnt_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    dec_cycle_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register; y is registered so reset clears it asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && in_valid) begin
                    state_d      = HOLD;
                    y_d          = dec_onehot(code);
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_d = IDLE;
                    y_d     = 8'h00;
                    cnt_clr = 1'b1;
                end else if (cnt_zero) begin
                    y_d = 8'h00;
                    if (GAP_CYCLES != 0) begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 8'h00;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Outputs; in_ready depends only on state and en, never on in_valid.
    always_comb begin
        in_ready = en && (state_q == IDLE);
        busy     = (state_q != IDLE);
        y        = y_q;
        y_valid  = |y_q;
    end

`ifdef DEC_ACCEPT_COUNT_EN
    logic             accept;
    logic [ACC_W-1:0] acc_q;

    assign accept = en && in_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && (acc_q != '1)) begin
            acc_q <= acc_q + ACC_W'(1);
        end
    end

    assign accept_cnt = acc_q;
`else
    assign accept_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_decoder_3x8_hold.sv
// Bench for decoder_3x8_hold: instance 0 uses the default hold/gap, instance 1
// has no gap. A timestamp model (cycles since the last accept) predicts outputs.
module tb_decoder_3x8_hold;

    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 4;
    localparam int G1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_s       [2];
    logic        in_valid_s [2];
    logic [2:0]  code_s     [2];
    logic        in_ready_s [2];
    logic [7:0]  y_s        [2];
    logic        y_valid_s  [2];
    logic        busy_s     [2];
    logic [15:0] acc_s      [2];

    int tests = 0;
    int fails = 0;

    // Model: edge counter and per-instance accept timestamp.
    int         e = 0;
    bit         m_active [2];
    int         m_k      [2];
    logic [2:0] m_code   [2];
    int         m_acc    [2];

    decoder_3x8_hold #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en_s[0]),
        .in_valid   (in_valid_s[0]),
        .in_ready   (in_ready_s[0]),
        .code       (code_s[0]),
        .y          (y_s[0]),
        .y_valid    (y_valid_s[0]),
        .busy       (busy_s[0]),
        .accept_cnt (acc_s[0])
    );

    decoder_3x8_hold #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut_nogap (
        .clk        (clk),
        .rst        (rst),
        .en         (en_s[1]),
        .in_valid   (in_valid_s[1]),
        .in_ready   (in_ready_s[1]),
        .code       (code_s[1]),
        .y          (y_s[1]),
        .y_valid    (y_valid_s[1]),
        .busy       (busy_s[1]),
        .accept_cnt (acc_s[1])
    );

    always #5 clk = ~clk;

    function automatic int hv(int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int gv(int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Busy for hold+gap cycles after the accept edge.
    function automatic bit m_busy(int i);
        return m_active[i] && ((e - m_k[i]) < (hv(i) + gv(i)));
    endfunction

    function automatic logic [7:0] m_y(int i);
        logic [7:0] one;
        int ph;
        one = 8'd1;
        ph  = e - m_k[i];
        if (m_active[i] && ph >= 0 && ph < hv(i)) return one << m_code[i];
        return 8'h00;
    endfunction

    function automatic bit m_ready(int i);
        return (en_s[i] === 1'b1) && !m_busy(i);
    endfunction

    function automatic logic [15:0] m_cnt(int i);
`ifdef DEC_ACCEPT_COUNT_EN
        return 16'(m_acc[i]);
`else
        return 16'(i - i);
`endif
    endfunction

    function automatic logic [15:0] exp_cnt(int n);
`ifdef DEC_ACCEPT_COUNT_EN
        return 16'(n);
`else
        return 16'(n - n);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_k[i]      = 0;
            m_code[i]   = 3'd0;
            m_acc[i]    = 0;
        end
    endtask

    // One clock edge; model updated from the inputs seen before the edge.
    task automatic tick();
        bit acc [2];
        bit abt [2];
        for (int i = 0; i < 2; i++) begin
            acc[i] = (rst === 1'b0) && (en_s[i] === 1'b1) && (in_valid_s[i] === 1'b1)
                     && !m_busy(i);
            abt[i] = (rst === 1'b0) && (en_s[i] === 1'b0) && m_busy(i);
        end
        @(posedge clk);
        e++;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                m_active[i] = 1'b1;
                m_k[i]      = e;
                m_code[i]   = code_s[i];
                if (m_acc[i] < 65535) m_acc[i]++;
            end else if (abt[i]) begin
                m_active[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drain(int i);
        for (int t = 0; t < 20; t++) begin
            if (!m_busy(i)) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en_s[i] = 1'b1;
            in_valid_s[i] = 1'b0;
            code_s[i] = 3'd0;
        end
        model_reset();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({y_s[i], y_valid_s[i], busy_s[i], acc_s[i]} !== {8'h00, 1'b0, 1'b0, 16'h0}) begin
                fails++;
                $display("FAIL reset_state[%0d]: y=%h yv=%b busy=%b cnt=%h, want 00 0 0 0000",
                         i, y_s[i], y_valid_s[i], busy_s[i], acc_s[i]);
            end
            tests++;
            if (in_ready_s[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_ready[%0d]: in_ready=%b want 1", i, in_ready_s[i]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_codes();
        int order [8];
        for (int i = 0; i < 8; i++) order[i] = i;
        for (int i = 7; i > 0; i--) begin
            int j;
            int tmp;
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int n = 0; n < 8; n++) begin
            logic [7:0] one;
            logic [7:0] want;
            int yc;
            int rdy;
            one  = 8'd1;
            want = one << order[n];
            code_s[0] = 3'(order[n]);
            in_valid_s[0] = 1'b1;
            tick();
            yc  = 0;
            rdy = -1;
            for (int t = 0; t <= 10; t++) begin
                tests++;
                if ({y_s[0], y_valid_s[0], busy_s[0], in_ready_s[0]} !==
                    {m_y(0), |m_y(0), m_busy(0), m_ready(0)}) begin
                    fails++;
                    $display("FAIL code%0d_cycle%0d: y/yv/busy/rdy=%h/%b/%b/%b want %h/%b/%b/%b",
                             order[n], t, y_s[0], y_valid_s[0], busy_s[0], in_ready_s[0],
                             m_y(0), |m_y(0), m_busy(0), m_ready(0));
                end
                if (y_s[0] === want) yc++;
                if (in_ready_s[0] === 1'b1) begin
                    rdy = t;
                    break;
                end
                code_s[0] = 3'($urandom);
                in_valid_s[0] = m_busy(0) ? 1'($urandom) : 1'b0;
                tick();
            end
            tests++;
            if (yc !== 4) begin
                fails++;
                $display("FAIL hold_len_code%0d: %0d cycles, want 4", order[n], yc);
            end
            tests++;
            if (rdy !== 5) begin
                fails++;
                $display("FAIL ready_delay_code%0d: %0d cycles, want 5", order[n], rdy);
            end
        end
        in_valid_s[0] = 1'b0;
        tests++;
        if (acc_s[0] !== exp_cnt(8)) begin
            fails++;
            $display("FAIL accept_cnt_8: got %0d want %0d", acc_s[0], exp_cnt(8));
        end
    endtask

    task automatic test_back_to_back();
        int yh;
        yh = 0;
        code_s[1] = 3'b101;
        in_valid_s[1] = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            tests++;
            if ({y_s[1], y_valid_s[1], busy_s[1], in_ready_s[1]} !==
                {m_y(1), |m_y(1), m_busy(1), m_ready(1)}) begin
                fails++;
                $display("FAIL b2b_cycle%0d: y/yv/busy/rdy=%h/%b/%b/%b want %h/%b/%b/%b",
                         t, y_s[1], y_valid_s[1], busy_s[1], in_ready_s[1],
                         m_y(1), |m_y(1), m_busy(1), m_ready(1));
            end
            if (y_s[1] === 8'b0010_0000) yh++;
        end
        in_valid_s[1] = 1'b0;
        tests++;
        if (yh !== 12) begin
            fails++;
            $display("FAIL b2b_hold_cycles: %0d want 12", yh);
        end
        tests++;
        if (acc_s[1] !== exp_cnt(3)) begin
            fails++;
            $display("FAIL b2b_accepts: got %0d want %0d", acc_s[1], exp_cnt(3));
        end
        drain(1);
    endtask

    task automatic test_en_drop();
        code_s[0] = 3'($urandom);
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick();
        en_s[0] = 1'b0;
        #1;
        tests++;
        if (in_ready_s[0] !== 1'b0) begin
            fails++;
            $display("FAIL endrop_ready_comb: in_ready=%b want 0", in_ready_s[0]);
        end
        tick();
        tests++;
        if ({y_s[0], y_valid_s[0], busy_s[0]} !== {8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL endrop_abort: y=%h yv=%b busy=%b want 00 0 0",
                     y_s[0], y_valid_s[0], busy_s[0]);
        end
        for (int t = 0; t < 3; t++) begin
            in_valid_s[0] = 1'($urandom);
            code_s[0] = 3'($urandom);
            tick();
            tests++;
            if ({y_s[0], busy_s[0], in_ready_s[0]} !== {m_y(0), m_busy(0), m_ready(0)}) begin
                fails++;
                $display("FAIL endrop_idle%0d: y/busy/rdy=%h/%b/%b want %h/%b/%b",
                         t, y_s[0], busy_s[0], in_ready_s[0], m_y(0), m_busy(0), m_ready(0));
            end
        end
        in_valid_s[0] = 1'b0;
        en_s[0] = 1'b1;
        #1;
        tests++;
        if (in_ready_s[0] !== 1'b1) begin
            fails++;
            $display("FAIL endrop_reenable: in_ready=%b want 1", in_ready_s[0]);
        end
    endtask

    task automatic test_reset_mid_hold();
        code_s[0] = 3'b111;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick();
        tests++;
        if (y_s[0] !== 8'h80) begin
            fails++;
            $display("FAIL rsthold_pre: y=%h want 80", y_s[0]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({y_s[0], y_valid_s[0], busy_s[0]} !== {8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rsthold_async: y=%h yv=%b busy=%b want 00 0 0",
                     y_s[0], y_valid_s[0], busy_s[0]);
        end
        tick();
        rst = 1'b0;
        code_s[0] = 3'b000;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tests++;
        if ({y_s[0], y_valid_s[0], in_ready_s[0]} !== {8'h01, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rsthold_first_accept: y=%h yv=%b rdy=%b want 01 1 0",
                     y_s[0], y_valid_s[0], in_ready_s[0]);
        end
        tests++;
        if (acc_s[0] !== exp_cnt(1)) begin
            fails++;
            $display("FAIL rsthold_count: got %0d want %0d", acc_s[0], exp_cnt(1));
        end
        drain(0);
    endtask

    task automatic test_en_low_idle();
        en_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            code_s[0] = 3'($urandom);
            tick();
            tests++;
            if ({y_s[0], busy_s[0], in_ready_s[0], acc_s[0]} !==
                {8'h00, 1'b0, 1'b0, m_cnt(0)}) begin
                fails++;
                $display("FAIL enlow_cycle%0d: y/busy/rdy/cnt=%h/%b/%b/%0d want 00/0/0/%0d",
                         t, y_s[0], busy_s[0], in_ready_s[0], acc_s[0], m_cnt(0));
            end
        end
        tests++;
        if (acc_s[0] !== exp_cnt(1)) begin
            fails++;
            $display("FAIL enlow_count: got %0d want %0d", acc_s[0], exp_cnt(1));
        end
        in_valid_s[0] = 1'b0;
        en_s[0] = 1'b1;
    endtask

    task automatic test_loopback();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            logic [7:0] oh;
            logic [2:0] enc;
            one = 8'd1;
            oh  = one << i;
            enc = 3'd0;
            for (int b = 0; b < 8; b++) if (oh[b]) enc = 3'(b);
            code_s[0] = enc;
            in_valid_s[0] = 1'b1;
            tick();
            in_valid_s[0] = 1'b0;
            tests++;
            if (y_s[0] !== oh) begin
                fails++;
                $display("FAIL loopback%0d: y=%h want %h", i, y_s[0], oh);
            end
            drain(0);
        end
        tests++;
        if (acc_s[0] !== m_cnt(0)) begin
            fails++;
            $display("FAIL loopback_count: got %0d want %0d", acc_s[0], m_cnt(0));
        end
    endtask

    initial begin
        test_reset();
        test_all_codes();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_hold();
        test_en_low_idle();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
